// File: rtl/sequence_pkg.sv
// Shared definitions for the LED sequence player: state encoding, default sizes,
// and the colour code to one-hot LED mapping.
package sequence_pkg;

  localparam int unsigned DefaultAw    = 4;
  localparam int unsigned DefaultDw    = 2;
  localparam int unsigned DefaultDepth = 10;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAddr = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StOn   = 3'd3;
  localparam logic [2:0] StOff  = 3'd4;
  localparam logic [2:0] StFin  = 3'd5;

  localparam logic [3:0] Red = 4'b0001;
  localparam logic [3:0] Grn = 4'b0010;
  localparam logic [3:0] Blu = 4'b0100;
  localparam logic [3:0] Yel = 4'b1000;

  function automatic logic [3:0] color_onehot(input logic [1:0] code);
    logic [3:0] oh;
    case (code)
      2'd0:    oh = Red;
      2'd1:    oh = Grn;
      2'd2:    oh = Blu;
      default: oh = Yel;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/sequence_player_phase_timer.sv
// Loadable down-counter that times the lit and dark phases; zero marks the
// final cycle of the current phase.
module phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays a stored colour sequence on a one-hot LED: each entry is fetched from an
// external registered-read memory, lit for ON_CYCLES, then dark for OFF_CYCLES.
module sequence_player
  import sequence_pkg::*;
#(
  parameter int unsigned AW         = DefaultAw,
  parameter int unsigned DW         = DefaultDw,
  parameter int unsigned DEPTH      = DefaultDepth,
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned OFF_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] seq_len,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [3:0]    led,
  output logic          busy,
  output logic          done
);

  localparam int unsigned MaxCycles = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW        = $clog2(MaxCycles + 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] addr_d;
  logic [AW-1:0] len_q, len_d;
  logic [DW-1:0] color_q, color_d;
  logic [AW-1:0] len_clamp;
  logic          t_load, t_dec, t_zero;
  logic [TW-1:0] t_val;

  assign len_clamp = (32'(seq_len) > DEPTH) ? AW'(DEPTH) : seq_len;

  phase_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (t_load),
    .load_val(t_val),
    .dec     (t_dec),
    .zero    (t_zero)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = rd_addr;
    len_d   = len_q;
    color_d = color_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_dec   = 1'b0;
    // abort wins over everything, including a start in the same cycle
    if (abort) begin
      if (state_q != StIdle) begin
        state_d = StIdle;
        idx_d   = '0;
        addr_d  = '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            idx_d  = '0;
            addr_d = '0;
            if (len_clamp == '0) begin
              state_d = StFin;
            end else begin
              len_d   = len_clamp;
              state_d = StAddr;
            end
          end
        end
        StAddr: state_d = StWait;
        StWait: begin
          color_d = rd_data;
          t_load  = 1'b1;
          t_val   = TW'(ON_CYCLES - 1);
          state_d = StOn;
        end
        StOn: begin
          if (t_zero) begin
            t_load  = 1'b1;
            t_val   = TW'(OFF_CYCLES - 1);
            state_d = StOff;
          end else begin
            t_dec = 1'b1;
          end
        end
        StOff: begin
          if (!t_zero) begin
            t_dec = 1'b1;
          end else if (idx_q == len_q - AW'(1)) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + AW'(1);
            addr_d  = rd_addr + AW'(1);
            state_d = StAddr;
          end
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      rd_addr <= '0;
      len_q   <= '0;
      color_q <= '0;
      led     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd_addr <= addr_d;
      len_q   <= len_d;
      color_q <= color_d;
      led     <= (state_d == StOn) ? color_onehot(2'(color_d)) : 4'b0000;
      busy    <= (state_d != StIdle);
      done    <= (state_d == StFin);
    end
  end

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player: a cycle-level expectation queue built from
// the timing contract is drained and compared after every clock edge.
module tb_sequence_player;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] seq_len;
  logic [3:0] rd_addr;
  logic [1:0] rd_data;
  logic [3:0] led;
  logic       busy;
  logic       done;

  logic [1:0] mem [16];

  int errors;
  int checks;
  int max_seen;

  typedef struct {
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic [3:0] addr;
    bit         chk_addr;
  } exp_t;

  exp_t sb[$];

  sequence_player dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .seq_len(seq_len),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .led    (led),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read sequence memory
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // abort_at / busy_start_at / stop_at are edge indices relative to the start edge (-1 = unused)
  task automatic play(input int len_in, input int abort_at, input int stop_at,
                      input int busy_start_at, input bit no_wait);
    int   l;
    int   n;
    int   ent;
    int   o;
    exp_t e;
    exp_t got;
    l = (len_in > 10) ? 10 : len_in;
    n = 8 * l + 2;
    max_seen = 0;
    if (!no_wait) @(negedge clk);
    seq_len = 4'(len_in);
    start   = 1'b1;
    for (int j = 0; j < n; j++) begin
      ent = j / 8;
      o   = j % 8;
      if (abort_at >= 0 && j >= abort_at) begin
        e = '{led: 4'b0, busy: 1'b0, done: 1'b0, addr: 4'b0, chk_addr: 1'b0};
      end else if (j < 8 * l) begin
        e.led      = (o >= 2 && o <= 5) ? (4'b0001 << mem[ent]) : 4'b0000;
        e.busy     = 1'b1;
        e.done     = 1'b0;
        e.addr     = 4'(ent);
        e.chk_addr = 1'b1;
      end else begin
        e.led      = 4'b0000;
        e.busy     = (j == 8 * l);
        e.done     = (j == 8 * l);
        e.addr     = (l == 0) ? 4'd0 : 4'(l - 1);
        e.chk_addr = 1'b1;
      end
      sb.push_back(e);
    end
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      start   = 1'b0;
      abort   = 1'b0;
      seq_len = 4'($urandom_range(15, 0));
      got = sb.pop_front();
      check($sformatf("led[j=%0d]", j), 32'(led), 32'(got.led));
      check($sformatf("busy[j=%0d]", j), 32'(busy), 32'(got.busy));
      check($sformatf("done[j=%0d]", j), 32'(done), 32'(got.done));
      if (got.chk_addr) check($sformatf("rd_addr[j=%0d]", j), 32'(rd_addr), 32'(got.addr));
      if (int'(rd_addr) > max_seen) max_seen = int'(rd_addr);
      if (j == busy_start_at - 1) begin
        start   = 1'b1;
        seq_len = 4'd0;
      end
      if (j == abort_at - 1) abort = 1'b1;
      if (j == stop_at) begin
        sb.delete();
        break;
      end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    seq_len = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    mem[0] = 2'd2;
    mem[1] = 2'd0;
    mem[2] = 2'd3;

    #12;
    check("reset_led", 32'(led), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_addr", 32'(rd_addr), 32'h0);

    // Release and start on the very first edge: single entry
    @(negedge clk);
    rst = 1'b0;
    play(1, -1, -1, -1, 1'b1);

    // Three entries, with a start pulse mid-run that must be ignored
    play(3, -1, -1, 4, 1'b0);

    // Zero length: straight to done
    play(0, -1, -1, -1, 1'b0);

    // Length above DEPTH is clamped to 10 entries
    for (int i = 0; i < 10; i++) mem[i] = 2'($urandom_range(3, 0));
    play(15, -1, -1, -1, 1'b0);
    check("clamp_max_addr", 32'(max_seen), 32'd9);
    mem[0] = 2'd2;
    mem[1] = 2'd0;
    mem[2] = 2'd3;

    // Abort during the second ON phase, then replay from address 0
    play(3, 11, -1, -1, 1'b0);
    play(3, -1, -1, -1, 1'b0);

    // Abort beats start while idle
    @(negedge clk);
    start   = 1'b1;
    abort   = 1'b1;
    seq_len = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("abort_over_start_busy", 32'(busy), 32'h0);
    check("abort_over_start_led", 32'(led), 32'h0);

    // Asynchronous reset in the dark gap
    play(1, -1, 6, -1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    check("async_rst_addr", 32'(rd_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    play(1, -1, -1, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
